// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: control/status bundle for pulse_stretch.
//   pulse_in     trigger strobe (one pulse per high cycle)
//   high_len     high window length in cycles (0 acts as 1)
//   gap_len      minimum low gap after each window (0 = no gap)
//   clr_dropped  clears the sticky dropped flag
//   level_out    stretched level
//   busy         stretcher not idle
//   pending      queued pulse count
//   dropped      sticky: a pulse was discarded
// master drives the strobes and lengths; slave is the stretcher.
interface pulse_stretch_if #(
    parameter int unsigned LEN_W = 8
);
    logic             pulse_in;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] gap_len;
    logic             clr_dropped;
    logic             level_out;
    logic             busy;
    logic [3:0]       pending;
    logic             dropped;

    modport master (
        output pulse_in, high_len, gap_len, clr_dropped,
        input  level_out, busy, pending, dropped
    );

    modport slave (
        input  pulse_in, high_len, gap_len, clr_dropped,
        output level_out, busy, pending, dropped
    );
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns one-cycle strobes into level windows of high_len cycles
// followed by a low gap of gap_len cycles.
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus_io  pulse_stretch_if slave (strobe, lengths, level/busy/pending/dropped)
// MODE selects what happens to pulses arriving while busy:
//   0 ignore (drop), 1 retrigger during HIGH (drop during GAP), 2 queue, 3 as 0.
// All outputs are registers.
module pulse_stretch #(
    parameter int unsigned LEN_W       = 8,
    parameter logic [1:0]  MODE        = 2'd0,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    pulse_stretch_if.slave  bus_io
);

    localparam bit         Retrig = (MODE == 2'd1);
    localparam bit         Queue  = (MODE == 2'd2);
    localparam logic [3:0] QMax   = 4'(QUEUE_DEPTH);

    typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic [3:0]       pend_q, pend_d;
    logic             drop_q, drop_d;

    logic [LEN_W-1:0] high_m1;
    logic [LEN_W-1:0] gap_m1;
    logic             pulse;
    logic             avail;
    logic             enq;
    logic             deq;
    logic             drop_evt;

    assign pulse   = bus_io.pulse_in;
    // high_len of 0 behaves as 1, so the reload value saturates at 0
    assign high_m1 = (bus_io.high_len == '0) ? '0 : bus_io.high_len - LEN_W'(1);
    assign gap_m1  = bus_io.gap_len - LEN_W'(1);
    // A window can restart from a queued pulse or, in queue mode, from the pulse
    // arriving this very cycle (which then never touches the counter).
    assign avail   = (pend_q != 4'd0) || (Queue && pulse);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enq      = 1'b0;
        deq      = 1'b0;
        drop_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pulse) begin
                    state_d = StHigh;
                    cnt_d   = high_m1;
                end
            end
            StHigh: begin
                if (Retrig && pulse) begin
                    cnt_d = high_m1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (bus_io.gap_len != '0) begin
                    state_d = StGap;
                    cnt_d   = gap_m1;
                end else if (avail) begin
                    cnt_d = high_m1;
                    deq   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
                if (pulse && !Retrig) begin
                    if (Queue) enq = 1'b1;
                    else       drop_evt = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (avail) begin
                    state_d = StHigh;
                    cnt_d   = high_m1;
                    deq     = 1'b1;
                end else begin
                    state_d = StIdle;
                end
                if (pulse) begin
                    if (Queue) enq = 1'b1;
                    else       drop_evt = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Simultaneous enqueue and dequeue cancel; the pulse is consumed, not dropped.
        pend_d = pend_q;
        if (enq && deq) begin
            pend_d = pend_q;
        end else if (deq) begin
            pend_d = pend_q - 4'd1;
        end else if (enq) begin
            if (pend_q == QMax) drop_evt = 1'b1;
            else                pend_d   = pend_q + 4'd1;
        end

        drop_d  = bus_io.clr_dropped ? 1'b0 : (drop_q | drop_evt);
        level_d = (state_d == StHigh);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 4'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    assign bus_io.level_out = level_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.pending   = pend_q;
    assign bus_io.dropped   = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: three stretcher instances (ignore, retrigger, queue depth 2).
// The driver pushes the hand-computed expected outputs for the cycle after each
// edge into a queue; a negedge monitor pops and compares them.
module tb_pulse_stretch;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int         at;
        int         sel;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    pulse_stretch_if #(.LEN_W(8)) if0 ();
    pulse_stretch_if #(.LEN_W(8)) if1 ();
    pulse_stretch_if #(.LEN_W(8)) if2 ();

    pulse_stretch #(.LEN_W(8), .MODE(2'd0), .QUEUE_DEPTH(4)) u_ign (
        .clk(clk), .rst_n(rst_n), .bus_io(if0)
    );
    pulse_stretch #(.LEN_W(8), .MODE(2'd1), .QUEUE_DEPTH(4)) u_ret (
        .clk(clk), .rst_n(rst_n), .bus_io(if1)
    );
    pulse_stretch #(.LEN_W(8), .MODE(2'd2), .QUEUE_DEPTH(2)) u_que (
        .clk(clk), .rst_n(rst_n), .bus_io(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] outs(int sel);
        case (sel)
            0:       return {if0.level_out, if0.busy, if0.pending, if0.dropped};
            1:       return {if1.level_out, if1.busy, if1.pending, if1.dropped};
            default: return {if2.level_out, if2.busy, if2.pending, if2.dropped};
        endcase
    endfunction

    task automatic check(string name, logic [6:0] got, logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got{lvl,busy,pend,drop}=%b want=%b",
                     name, cyc, got, want);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.at < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale expectation at=%0d now=%0d", e.name, e.at, cyc);
            end else begin
                check(e.name, outs(e.sel), e.val);
            end
        end
    end

    task automatic drive(int sel, bit p, bit c);
        case (sel)
            0:       begin if0.pulse_in = p; if0.clr_dropped = c; end
            1:       begin if1.pulse_in = p; if1.clr_dropped = c; end
            default: begin if2.pulse_in = p; if2.clr_dropped = c; end
        endcase
    endtask

    task automatic set_len(int sel, logic [7:0] hl, logic [7:0] gl);
        case (sel)
            0:       begin if0.high_len = hl; if0.gap_len = gl; end
            1:       begin if1.high_len = hl; if1.gap_len = gl; end
            default: begin if2.high_len = hl; if2.gap_len = gl; end
        endcase
    endtask

    task automatic expect_at(int sel, int at, bit l, bit b, logic [3:0] pd, bit d,
                             string name);
        exp_t e;
        e.at   = at;
        e.sel  = sel;
        e.val  = {l, b, pd, d};
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs for the next edge; expect outputs after that edge.
    task automatic step(int sel, bit p, bit c, bit l, bit b, logic [3:0] pd, bit d,
                        string name);
        drive(sel, p, c);
        expect_at(sel, cyc + 1, l, b, pd, d, name);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 1'b0);
            set_len(s, 8'd1, 8'd0);
        end
        #1;
        for (int s = 0; s < 3; s++) check("reset_state", outs(s), 7'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Ignore mode: single window, high 5, gap 3.
        set_len(0, 8'd5, 8'd3);
        step(0, 1, 0, 1, 1, 0, 0, "ign_single_start");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0, "ign_single_high");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "ign_single_gap");
        step(0, 0, 0, 0, 0, 0, 0, "ign_single_idle");

        // Ignore mode: second pulse mid-window is dropped, window unchanged.
        set_len(0, 8'd4, 8'd2);
        step(0, 1, 0, 1, 1, 0, 0, "ign_drop_start");
        step(0, 0, 0, 1, 1, 0, 0, "ign_drop_high");
        step(0, 1, 0, 1, 1, 0, 1, "ign_drop_set");
        step(0, 0, 0, 1, 1, 0, 1, "ign_drop_high_last");
        step(0, 0, 0, 0, 1, 0, 1, "ign_drop_gap");
        step(0, 0, 0, 0, 1, 0, 1, "ign_drop_gap");
        step(0, 0, 0, 0, 0, 0, 1, "ign_drop_idle");
        step(0, 0, 1, 0, 0, 0, 0, "ign_clr");
        // clr_dropped wins over a drop in the same cycle.
        step(0, 1, 0, 1, 1, 0, 0, "ign_prio_start");
        step(0, 1, 1, 1, 1, 0, 0, "ign_prio_clr_wins");
        step(0, 0, 0, 1, 1, 0, 0, "ign_prio_high");
        step(0, 0, 0, 1, 1, 0, 0, "ign_prio_high");
        step(0, 0, 0, 0, 1, 0, 0, "ign_prio_gap");
        step(0, 0, 0, 0, 1, 0, 0, "ign_prio_gap");
        step(0, 0, 0, 0, 0, 0, 0, "ign_prio_idle");

        // Retrigger: high 4, gap 0, pulses 3 cycles apart -> 7 high cycles.
        set_len(1, 8'd4, 8'd0);
        step(1, 1, 0, 1, 1, 0, 0, "ret_start");
        step(1, 0, 0, 1, 1, 0, 0, "ret_high");
        step(1, 0, 0, 1, 1, 0, 0, "ret_high");
        step(1, 1, 0, 1, 1, 0, 0, "ret_reload");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 0, "ret_extended");
        step(1, 0, 0, 0, 0, 0, 0, "ret_idle");
        // Retrigger during GAP is dropped.
        set_len(1, 8'd2, 8'd2);
        step(1, 1, 0, 1, 1, 0, 0, "ret_gap_start");
        step(1, 0, 0, 1, 1, 0, 0, "ret_gap_high");
        step(1, 0, 0, 0, 1, 0, 0, "ret_gap_gap");
        step(1, 1, 0, 0, 1, 0, 1, "ret_gap_drop");
        step(1, 0, 0, 0, 0, 0, 1, "ret_gap_idle");
        step(1, 0, 1, 0, 0, 0, 0, "ret_clr");

        // Queue depth 2: high 3, gap 2, four back-to-back pulses.
        set_len(2, 8'd3, 8'd2);
        step(2, 1, 0, 1, 1, 0, 0, "que_w1");
        step(2, 1, 0, 1, 1, 1, 0, "que_enq1");
        step(2, 1, 0, 1, 1, 2, 0, "que_enq2");
        step(2, 1, 0, 0, 1, 2, 1, "que_sat_drop");
        step(2, 0, 0, 0, 1, 2, 1, "que_gap1");
        for (int i = 0; i < 3; i++) step(2, 0, 0, 1, 1, 1, 1, "que_w2");
        for (int i = 0; i < 2; i++) step(2, 0, 0, 0, 1, 1, 1, "que_gap2");
        for (int i = 0; i < 3; i++) step(2, 0, 0, 1, 1, 0, 1, "que_w3");
        for (int i = 0; i < 2; i++) step(2, 0, 0, 0, 1, 0, 1, "que_gap3");
        step(2, 0, 0, 0, 0, 0, 1, "que_idle");
        step(2, 0, 1, 0, 0, 0, 0, "que_clr");

        // Queue, gap 0, high 2, three pulses -> 6 contiguous high cycles.
        set_len(2, 8'd2, 8'd0);
        step(2, 1, 0, 1, 1, 0, 0, "que_nogap_w1");
        step(2, 1, 0, 1, 1, 1, 0, "que_nogap_enq");
        step(2, 1, 0, 1, 1, 1, 0, "que_nogap_net0");
        step(2, 0, 0, 1, 1, 1, 0, "que_nogap_w2");
        step(2, 0, 0, 1, 1, 0, 0, "que_nogap_w3");
        step(2, 0, 0, 1, 1, 0, 0, "que_nogap_w3");
        step(2, 0, 0, 0, 0, 0, 0, "que_nogap_idle");

        // Queue: pulse in last GAP cycle starts the next window at once.
        set_len(2, 8'd2, 8'd2);
        step(2, 1, 0, 1, 1, 0, 0, "que_edge_w1");
        step(2, 0, 0, 1, 1, 0, 0, "que_edge_w1");
        step(2, 0, 0, 0, 1, 0, 0, "que_edge_gap");
        step(2, 0, 0, 0, 1, 0, 0, "que_edge_gap_last");
        step(2, 1, 0, 1, 1, 0, 0, "que_edge_restart");
        step(2, 0, 0, 1, 1, 0, 0, "que_edge_w2");
        step(2, 0, 0, 0, 1, 0, 0, "que_edge_gap2");
        step(2, 0, 0, 0, 1, 0, 0, "que_edge_gap2");
        step(2, 0, 0, 0, 0, 0, 0, "que_edge_idle");

        // high_len 0 behaves as a 1-cycle window.
        set_len(0, 8'd0, 8'd0);
        step(0, 1, 0, 1, 1, 0, 0, "hl0_high");
        step(0, 0, 0, 0, 0, 0, 0, "hl0_idle");

        // Asynchronous reset mid-window, with a queued pulse pending.
        set_len(0, 8'd5, 8'd0);
        set_len(2, 8'd5, 8'd0);
        drive(0, 1, 0);
        drive(2, 1, 0);
        expect_at(0, cyc + 1, 1, 1, 0, 0, "rst_pre_ign");
        expect_at(2, cyc + 1, 1, 1, 0, 0, "rst_pre_que");
        tick();
        drive(0, 0, 0);
        expect_at(0, cyc + 1, 1, 1, 0, 0, "rst_pre_ign");
        expect_at(2, cyc + 1, 1, 1, 1, 0, "rst_pre_que");
        tick();
        drive(2, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) check("rst_async", outs(s), 7'b0);
        tick();
        check("rst_held_ign", outs(0), 7'b0);
        check("rst_held_que", outs(2), 7'b0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_at(2, cyc + 1, 0, 0, 0, 0, "rst_no_resume_que");
            step(0, 0, 0, 0, 0, 0, 0, "rst_no_resume_ign");
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Converts single-cycle pulses (the output of the edge-to-pulse generators) back into stable level windows of programmable high time, followed by a programmable minimum low gap.
- Used to drive LEDs, buzzer enables, handshake request levels and slow peripherals from one-cycle event strobes.
- Per-instance policy for pulses arriving while a window is active: ignore, retrigger, or queue.

Parameters:
- LEN_W, 8: width of the high_len and gap_len inputs and of the internal down-counter.
- MODE, 2'd0: policy for pulses arriving while not IDLE. 0 = ignore, 1 = retrigger, 2 = queue. 3 is illegal and behaves as 0.
- QUEUE_DEPTH, 4: maximum number of pending pulses (MODE 2 only). Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pulse_in  in  1  trigger strobe, sampled each rising edge. Multi-cycle high counts as one pulse per high cycle.
- high_len  in  LEN_W  high window length in cycles; 0 is treated as 1.
- gap_len  in  LEN_W  minimum low gap after each window in cycles; 0 means no gap.
- clr_dropped  in  1  clears the dropped flag.
- level_out  out  1  stretched level; registered, glitch-free.
- busy  out  1  high whenever state is not IDLE; registered.
- pending  out  4  queued pulse count; always 0 unless MODE 2.
- dropped  out  1  sticky flag: a pulse was discarded.

Behaviour:
- Reset: while rst_n is low, state = IDLE and level_out, busy, pending, dropped are all 0. Assertion mid-window aborts the window immediately (asynchronously).
- States: IDLE, HIGH, GAP. Counter cnt is LEN_W bits.
- Length sampling: high_len and gap_len are sampled only on entry to HIGH or GAP. Changes mid-phase have no effect on that phase.
- IDLE, pulse_in=1 at edge N: enter HIGH, cnt = max(high_len,1)-1, level_out=1 from edge N. Latency is 1 cycle from pulse_in rising to level_out rising.
- HIGH: level_out=1. If cnt != 0, decrement. If cnt == 0:
  - gap_len != 0: enter GAP, cnt = gap_len-1, level_out=0.
  - gap_len == 0, no pending: enter IDLE, level_out=0.
  - gap_len == 0, pending: enter HIGH again. level_out stays 1 with no low cycle.
  - Result: level_out is high for exactly max(high_len,1) cycles per window.
- GAP: level_out=0. If cnt != 0, decrement. If cnt == 0: enter HIGH if pending != 0, else IDLE. The gap is exactly gap_len cycles.
- Pulse while HIGH or GAP, by MODE:
  - Ignore: pulse discarded, dropped=1.
  - Retrigger, during HIGH: cnt reloads to max(high_len,1)-1 (window extends; high_len re-sampled).
  - Retrigger, during GAP: pulse discarded, dropped=1.
  - Queue: pending increments, saturating at QUEUE_DEPTH. A pulse arriving at saturation is discarded and sets dropped=1.
- Queue dequeue: on a HIGH-restart from pending, pending decrements. If pulse_in=1 in the same cycle, pending is unchanged (net 0) and dropped is not set.
- Transition-edge pulse: a pulse in the last cycle of GAP (cnt==0) follows the GAP rule for the current MODE. Queue mode therefore starts it as the next window immediately.
- dropped priority: clr_dropped has priority over a simultaneous set. The pulse is still discarded, but the flag reads 0 next cycle.
- busy = (state != IDLE). It drops in the same cycle level_out drops on the final IDLE return.
- All outputs come directly from registers. No combinational path from inputs to outputs.

Test Plan:
- Reset then single pulse, high_len=5, gap_len=3, MODE 0: level_out high exactly cycles 1..5 after the pulse; busy high 8 cycles; pending=0, dropped=0.
- MODE 0, high_len=4, gap_len=2, second pulse 2 cycles into the window: window unchanged (4 cycles), dropped=1. Pulse clr_dropped: dropped=0 next cycle.
- MODE 1, high_len=4, gap_len=0, pulses at t=0 and t=3: level_out high continuously for 7 cycles (t+1..t+7); dropped=0.
- MODE 2, QUEUE_DEPTH=2, high_len=3, gap_len=2, 4 back-to-back pulses: pending reaches 2, dropped=1. Three 3-cycle windows separated by exactly 2 low cycles; pending returns to 0; busy falls after the final gap.
- MODE 2, gap_len=0, high_len=2, 3 pulses: level_out high continuously for 6 cycles, then low.
- high_len=0 edge case: 1-cycle window. rst_n asserted mid-HIGH: level_out, busy, pending all 0 asynchronously, and no window resumes after release.
